// File: rtl/writeback_arbiter.sv
// Writeback stage: merges load responses and FIFO-buffered ALU results
// into the register-file write port and reports pending writes to decode.
module writeback_arbiter #(
  parameter int LOG2_NUM_REGISTERS = 5,
  parameter int ALU_FIFO_DEPTH     = 2,
  parameter int CPU_DATA_BITS      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [LOG2_NUM_REGISTERS-1:0] alu_rd,
  input  logic [CPU_DATA_BITS-1:0]      alu_data,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [LOG2_NUM_REGISTERS-1:0] ld_rd,
  input  logic [CPU_DATA_BITS-1:0]      ld_data,
  input  logic [2:0]                    ld_funct3,
  input  logic [1:0]                    ld_offset,
  output logic [LOG2_NUM_REGISTERS-1:0] waddr,
  output logic [CPU_DATA_BITS-1:0]      wdata,
  output logic                          write_enable,
  input  logic [LOG2_NUM_REGISTERS-1:0] chk_addr,
  output logic                          chk_pending
);

  localparam int PW = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(ALU_FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(ALU_FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(ALU_FIFO_DEPTH);

  logic [LOG2_NUM_REGISTERS-1:0] r_rd   [ALU_FIFO_DEPTH];
  logic [CPU_DATA_BITS-1:0]      r_data [ALU_FIFO_DEPTH];
  logic [ALU_FIFO_DEPTH-1:0]     r_vld;
  logic [PW-1:0]                 r_wptr;
  logic [PW-1:0]                 r_rptr;
  logic [CW-1:0]                 r_count;
  logic [LOG2_NUM_REGISTERS-1:0] r_waddr;
  logic [CPU_DATA_BITS-1:0]      r_wdata;
  logic                          r_we;

  logic                          w_empty;
  logic                          w_full;
  logic                          w_ld_acc;
  logic                          w_alu_acc;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_sel;
  logic [LOG2_NUM_REGISTERS-1:0] w_sel_rd;
  logic [CPU_DATA_BITS-1:0]      w_sel_data;
  logic [7:0]                    w_byte;
  logic [15:0]                   w_half;
  logic [CPU_DATA_BITS-1:0]      w_ld_ext;
  logic                          w_hit;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL);
  assign alu_ready = !reset && !w_full;
  assign ld_ready  = !reset;
  assign w_ld_acc  = ld_valid && ld_ready;
  assign w_alu_acc = alu_valid && alu_ready;
  assign w_pop     = !w_ld_acc && !w_empty;
  // Bypass only when nothing older is queued and no load wins the port
  assign w_push    = w_alu_acc && (w_ld_acc || !w_empty);

  always_comb begin
    w_byte = 8'(ld_data >> {ld_offset, 3'b000});
    w_half = 16'(ld_data >> {ld_offset[1], 4'b0000});
    case (ld_funct3)
      3'b000:  w_ld_ext = {{(CPU_DATA_BITS-8){w_byte[7]}}, w_byte};
      3'b001:  w_ld_ext = {{(CPU_DATA_BITS-16){w_half[15]}}, w_half};
      3'b100:  w_ld_ext = {{(CPU_DATA_BITS-8){1'b0}}, w_byte};
      3'b101:  w_ld_ext = {{(CPU_DATA_BITS-16){1'b0}}, w_half};
      default: w_ld_ext = ld_data;
    endcase
  end

  always_comb begin
    w_sel      = 1'b0;
    w_sel_rd   = r_rd[r_rptr];
    w_sel_data = r_data[r_rptr];
    if (w_ld_acc) begin
      w_sel      = 1'b1;
      w_sel_rd   = ld_rd;
      w_sel_data = w_ld_ext;
    end else if (!w_empty) begin
      w_sel      = 1'b1;
    end else if (w_alu_acc) begin
      w_sel      = 1'b1;
      w_sel_rd   = alu_rd;
      w_sel_data = alu_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
      r_vld   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      if (w_push) begin
        r_rd[r_wptr]   <= alu_rd;
        r_data[r_wptr] <= alu_data;
        r_vld[r_wptr]  <= 1'b1;
        r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_sel) begin
        r_waddr <= w_sel_rd;
        r_wdata <= w_sel_data;
        r_we    <= (w_sel_rd != '0);
      end else begin
        r_we    <= 1'b0;
      end
    end
  end

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
      if (r_vld[i] && (r_rd[i] == chk_addr)) w_hit = 1'b1;
    end
    if (r_we && (r_waddr == chk_addr))   w_hit = 1'b1;
    if (w_alu_acc && (alu_rd == chk_addr)) w_hit = 1'b1;
    if (w_ld_acc && (ld_rd == chk_addr))   w_hit = 1'b1;
  end

  assign chk_pending  = w_hit && (chk_addr != '0);
  assign waddr        = r_waddr;
  assign wdata        = r_wdata;
  assign write_enable = r_we;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, bypass, load extension,
// collisions, starvation, hazard query and mid-stream reset.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        write_enable;
  logic [4:0]  chk_addr;
  logic        chk_pending;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  writeback_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_funct3(ld_funct3), .ld_offset(ld_offset),
    .waddr(waddr), .wdata(wdata), .write_enable(write_enable),
    .chk_addr(chk_addr), .chk_pending(chk_pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    ld_valid  = 1'b0;
    ld_rd     = '0;
    ld_data   = '0;
    ld_funct3 = 3'b010;
    ld_offset = 2'b00;
  endtask

  task automatic test_reset();
    idle();
    chk_addr = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_vec++;
    if (write_enable !== 1'b0) begin
      n_err++; $display("FAIL reset_we: got %b want 0", write_enable);
    end
    n_vec++;
    if (waddr !== 5'd0) begin
      n_err++; $display("FAIL reset_waddr: got %0d want 0", waddr);
    end
    n_vec++;
    if (wdata !== 32'd0) begin
      n_err++; $display("FAIL reset_wdata: got %h want 0", wdata);
    end
    n_vec++;
    if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: got alu %b ld %b want 0 0", alu_ready, ld_ready);
    end
    step();
    step();
    reset = 1'b0;
    #1;
    n_vec++;
    if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_ready: got alu %b ld %b want 1 1", alu_ready, ld_ready);
    end
  endtask

  task automatic test_alu_single();
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEADBEEF;
    step();
    idle();
    n_vec++;
    if (write_enable !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL alu_single: got we %b rd %0d data %h want 1 5 deadbeef", write_enable, waddr, wdata);
    end
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 32'h00001234;
    step();
    idle();
    n_vec++;
    if (write_enable !== 1'b0 || wdata !== 32'h00001234) begin
      n_err++;
      $display("FAIL alu_rd0: got we %b data %h want 0 00001234", write_enable, wdata);
    end
    step();
    n_vec++;
    if (write_enable !== 1'b0 || waddr !== 5'd0 || wdata !== 32'h00001234) begin
      n_err++;
      $display("FAIL idle_hold: got we %b rd %0d data %h want 0 0 00001234", write_enable, waddr, wdata);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3  [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010,
                             3'b011, 3'b001, 3'b000};
    logic [1:0]  off [8] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2};
    logic [31:0] exp [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1,
                             32'h00007F01, 32'h80F17F01, 32'h80F17F01,
                             32'hFFFF80F1, 32'hFFFFFFF1};
    for (int i = 0; i < 8; i++) begin
      ld_valid  = 1'b1;
      ld_rd     = 5'd9;
      ld_data   = 32'h80F17F01;
      ld_funct3 = f3[i];
      ld_offset = off[i];
      step();
      n_vec++;
      if (write_enable !== 1'b1 || waddr !== 5'd9 || wdata !== exp[i]) begin
        n_err++;
        $display("FAIL load_ext[%0d]: got we %b rd %0d data %h want 1 9 %h", i, write_enable, waddr, wdata, exp[i]);
      end
    end
    idle();
    step();
  endtask

  task automatic test_collision();
    ld_valid  = 1'b1;
    ld_rd     = 5'd3;
    ld_data   = 32'hAAAA5555;
    alu_valid = 1'b1;
    alu_rd    = 5'd4;
    alu_data  = 32'h0BADF00D;
    step();
    idle();
    n_vec++;
    if (write_enable !== 1'b1 || waddr !== 5'd3 || wdata !== 32'hAAAA5555) begin
      n_err++;
      $display("FAIL collide_ld: got we %b rd %0d data %h want 1 3 aaaa5555", write_enable, waddr, wdata);
    end
    step();
    n_vec++;
    if (write_enable !== 1'b1 || waddr !== 5'd4 || wdata !== 32'h0BADF00D) begin
      n_err++;
      $display("FAIL collide_alu: got we %b rd %0d data %h want 1 4 0badf00d", write_enable, waddr, wdata);
    end
    step();
    n_vec++;
    if (write_enable !== 1'b0) begin
      n_err++; $display("FAIL collide_drain: got we %b want 0", write_enable);
    end
  endtask

  task automatic test_starvation();
    logic       ldv [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       av  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] ard [7] = '{5'd1, 5'd2, 5'd3, 5'd3, 5'd3, 5'd3, 5'd0};
    logic       rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] wa  [7] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd1, 5'd2, 5'd3};
    for (int c = 0; c < 7; c++) begin
      ld_valid  = ldv[c];
      ld_rd     = 5'(10 + c);
      ld_data   = 32'(c);
      alu_valid = av[c];
      alu_rd    = ard[c];
      alu_data  = {27'd0, ard[c]} * 32'h11;
      #1;
      n_vec++;
      if (alu_ready !== rdy[c]) begin
        n_err++; $display("FAIL starve_ready[%0d]: got %b want %b", c, alu_ready, rdy[c]);
      end
      step();
      n_vec++;
      if (write_enable !== 1'b1 || waddr !== wa[c]) begin
        n_err++;
        $display("FAIL starve_write[%0d]: got we %b rd %0d want 1 %0d", c, write_enable, waddr, wa[c]);
      end
    end
    idle();
    n_vec++;
    if (wdata !== 32'h33) begin
      n_err++; $display("FAIL starve_data: got %h want 00000033", wdata);
    end
    step();
    n_vec++;
    if (write_enable !== 1'b0) begin
      n_err++; $display("FAIL starve_drain: got we %b want 0", write_enable);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'(i);
      alu_data  = 32'(i * 100);
      step();
      n_vec++;
      if (write_enable !== 1'b1 || waddr !== 5'(i) || wdata !== 32'(i * 100)) begin
        n_err++;
        $display("FAIL b2b[%0d]: got we %b rd %0d data %0d want 1 %0d %0d", i, write_enable, waddr, wdata, i, i * 100);
      end
    end
    idle();
    step();
  endtask

  task automatic test_hazard();
    chk_addr  = 5'd7;
    ld_valid  = 1'b1;
    ld_rd     = 5'd8;
    alu_valid = 1'b1;
    alu_rd    = 5'd7;
    #1;
    n_vec++;
    if (chk_pending !== 1'b1) begin
      n_err++; $display("FAIL hz_accept: got %b want 1", chk_pending);
    end
    step();
    idle();
    #1;
    n_vec++;
    if (chk_pending !== 1'b1) begin
      n_err++; $display("FAIL hz_fifo: got %b want 1", chk_pending);
    end
    chk_addr = 5'd0;
    #1;
    n_vec++;
    if (chk_pending !== 1'b0) begin
      n_err++; $display("FAIL hz_zero: got %b want 0", chk_pending);
    end
    chk_addr = 5'd8;
    #1;
    n_vec++;
    if (chk_pending !== 1'b1) begin
      n_err++; $display("FAIL hz_wport: got %b want 1", chk_pending);
    end
    chk_addr = 5'd7;
    step();
    n_vec++;
    if (chk_pending !== 1'b1 || write_enable !== 1'b1 || waddr !== 5'd7) begin
      n_err++;
      $display("FAIL hz_write: got pend %b we %b rd %0d want 1 1 7", chk_pending, write_enable, waddr);
    end
    step();
    n_vec++;
    if (chk_pending !== 1'b0) begin
      n_err++; $display("FAIL hz_clear: got %b want 0", chk_pending);
    end
  endtask

  task automatic test_reset_midstream();
    ld_valid  = 1'b1;
    ld_rd     = 5'd20;
    alu_valid = 1'b1;
    alu_rd    = 5'd21;
    step();
    ld_rd     = 5'd22;
    alu_rd    = 5'd23;
    step();
    idle();
    n_vec++;
    if (write_enable !== 1'b1 || waddr !== 5'd22) begin
      n_err++; $display("FAIL mid_setup: got we %b rd %0d want 1 22", write_enable, waddr);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (write_enable !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0 || alu_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got we %b rd %0d data %h rdy %b want 0 0 0 0", write_enable, waddr, wdata, alu_ready);
    end
    step();
    reset = 1'b0;
    chk_addr = 5'd21;
    #1;
    n_vec++;
    if (alu_ready !== 1'b1 || chk_pending !== 1'b0) begin
      n_err++;
      $display("FAIL mid_release: got rdy %b pend %b want 1 0", alu_ready, chk_pending);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (write_enable !== 1'b0) begin
        n_err++; $display("FAIL mid_stale[%0d]: got we %b rd %0d want 0", i, write_enable, waddr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_load_ext();
    test_collision();
    test_starvation();
    test_back_to_back();
    test_hazard();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage of the CPU pipeline. It sits directly upstream of the integer register file and drives that file's single write port (`waddr`, `wdata`, `write_enable`). It merges two result sources: ALU results through a small in-order FIFO, and load responses from data memory, which are aligned and sign- or zero-extended here. It also reports per-register pending writes so decode can stall on read-after-write hazards.

## Interface
Parameters:
- `LOG2_NUM_REGISTERS`, default 5: width of register addresses.
- `ALU_FIFO_DEPTH`, default 2: number of ALU result entries buffered; must be ≥1.

Ports:
- `clk` in 1: the single clock. All state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `alu_valid` in 1: an ALU result is offered.
- `alu_ready` out 1: the offered ALU result is accepted this cycle.
- `alu_rd` in `LOG2_NUM_REGISTERS`: destination register of the ALU result.
- `alu_data` in `CPU_DATA_BITS`: ALU result value.
- `ld_valid` in 1: a load response is offered.
- `ld_ready` out 1: the offered load response is accepted this cycle.
- `ld_rd` in `LOG2_NUM_REGISTERS`: destination register of the load.
- `ld_data` in `CPU_DATA_BITS`: raw aligned 32-bit word from memory.
- `ld_funct3` in 3: load type.
- `ld_offset` in 2: byte address bits [1:0] of the load.
- `waddr` out `LOG2_NUM_REGISTERS`: register-file write address, registered.
- `wdata` out `CPU_DATA_BITS`: register-file write data, registered.
- `write_enable` out 1: register-file write strobe, registered.
- `chk_addr` in `LOG2_NUM_REGISTERS`: register address queried by decode.
- `chk_pending` out 1: combinational; high if a write to `chk_addr` is still outstanding.

## Operation
Reset while `reset` is high:
- FIFO is emptied and its pointers and count are set to 0.
- `write_enable`, `waddr` and `wdata` are 0.
- `alu_ready` and `ld_ready` are 0.
- Reset takes effect immediately, including mid-stream. In-flight entries are discarded, not written.

Handshakes:
- `ld_ready` is 1 whenever `reset` is low. Loads are never backpressured.
- `alu_ready` = !fifo_full. The FIFO state used is the registered state, so a pop in the same cycle does not free a slot until the next cycle.
- A transfer happens when valid && ready at a rising edge.

Selection, one write per cycle, in priority order:
1. A load accepted this cycle goes to the output register.
2. Otherwise, if the FIFO is non-empty, the head is popped to the output register.
3. Otherwise, an ALU result accepted this cycle bypasses the FIFO into the output register.

In all other cases an accepted ALU result is pushed at the FIFO tail. ALU results are written in acceptance order.

Output register:
- `waddr` and `wdata` take the selected value.
- `write_enable` is 1 only if an entry was selected and its rd is nonzero.
- Entries with rd = 0 are consumed silently with `write_enable` = 0.
- With no selection, `write_enable` = 0 and `waddr`/`wdata` hold their values.

Load extension. Byte B = `ld_data[8*ld_offset +: 8]`; half H = `ld_data[16*ld_offset[1] +: 16]`, with `ld_offset[0]` ignored for halves.
- `funct3` 000 (LB): sign-extend B.
- `funct3` 001 (LH): sign-extend H.
- `funct3` 010 (LW): full word.
- `funct3` 100 (LBU): zero-extend B.
- `funct3` 101 (LHU): zero-extend H.
- `funct3` 011, 110 and 111 are treated as LW.

`chk_pending` is 1 iff `chk_addr` ≠ 0 and `chk_addr` matches any of:
- any valid FIFO entry's rd;
- `waddr` while `write_enable` = 1;
- `alu_rd` while `alu_valid && alu_ready`;
- `ld_rd` while `ld_valid && ld_ready`.

## Timing
- Latency from acceptance to `write_enable` high is 1 cycle, for a load, or for an ALU result that bypasses the FIFO. The register file updates on the following edge.
- An ALU result that enters the FIFO is written after all older entries, and only in cycles with no accepted load.
- Continuous loads starve the FIFO. When the FIFO fills, `alu_ready` drops until a load-free cycle pops an entry.
- Sustained throughput is one write per cycle.
- When the FIFO is full, a push is impossible in the same cycle as a pop.

## Test plan
- Reset mid-stream: assert `reset` with 2 FIFO entries and `write_enable` = 1 → outputs are 0 and `alu_ready` = 0 immediately. After release, `alu_ready` = 1 and no stale write occurs.
- Single ALU result, rd = 5, data 0xDEADBEEF, idle otherwise → next cycle `write_enable` = 1, `waddr` = 5, `wdata` = 0xDEADBEEF. A result with rd = 0 gives `write_enable` = 0.
- Load extension on `ld_data` = 0x80F17F01: LB off 3 → 0xFFFFFF80; LBU off 3 → 0x00000080; LH off 2 → 0xFFFF80F1; LHU off 0 → 0x00007F01; LW → 0x80F17F01.
- Collision: load (rd 3) and ALU result (rd 4) accepted in the same cycle → rd 3 written in cycle N+1, rd 4 in N+2.
- Starvation: 4 consecutive loads while ALU results rd 1, 2, 3 are offered → `alu_ready` drops after 2 ALU acceptances. After the loads end, rd 1 then rd 2 are written, then rd 3 is accepted and written, in order.
- Hazard query: `chk_addr` = 7 while rd 7 sits in the FIFO → `chk_pending` = 1. It stays 1 through the cycle `write_enable` is high for rd 7 and is 0 the cycle after. `chk_addr` = 0 always gives 0.
